// File: rtl/fixed_pkg.sv
// Shared Q15 fixed-point constants and saturation helpers for the
// multiply and accumulate stages.
package fixed_pkg;

   localparam logic signed [15:0] Q15_MAX = 16'sh7FFF;
   localparam logic signed [15:0] Q15_MIN = 16'sh8000;
   localparam int MUL_LAT = 5;

   // Callers sign-extend their operand to this width before saturating.
   localparam int SAT_IN_W = 64;
   localparam logic signed [SAT_IN_W-1:0] SAT_HI = 64'sd32767;
   localparam logic signed [SAT_IN_W-1:0] SAT_LO = -64'sd32768;

   function automatic logic is_clip16(input logic signed [SAT_IN_W-1:0] x);
      return (x > SAT_HI) || (x < SAT_LO);
   endfunction

   function automatic logic signed [15:0] sat16(input logic signed [SAT_IN_W-1:0] x);
      if (x > SAT_HI) begin
         return Q15_MAX;
      end else if (x < SAT_LO) begin
         return Q15_MIN;
      end else begin
         return x[15:0];
      end
   endfunction

endpackage

// File: rtl/mult.sv
// Five-stage saturating Q15 multiplier: p = sat16(floor(a*b / 2^15)).
// No enable; a new operand pair may enter every cycle.
module mult
   import fixed_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic signed [15:0] i_a,
   input  logic signed [15:0] i_b,
   output logic signed [15:0] o_p
);

   logic signed [15:0] r_a;
   logic signed [15:0] r_b;
   logic signed [31:0] r_full;
   logic signed [15:0] r_p3;
   logic signed [15:0] r_p4;
   logic signed [15:0] r_p5;
   logic signed [31:0] w_shift;

   // Arithmetic shift gives floor rounding; only -1.0 * -1.0 exceeds Q15.
   assign w_shift = r_full >>> 15;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_full <= '0;
         r_p3   <= '0;
         r_p4   <= '0;
         r_p5   <= '0;
      end else begin
         r_a    <= i_a;
         r_b    <= i_b;
         r_full <= 32'(r_a) * 32'(r_b);
         r_p3   <= sat16(SAT_IN_W'(w_shift));
         r_p4   <= r_p3;
         r_p5   <= r_p4;
      end
   end

   assign o_p = r_p5;

endmodule

// File: rtl/dot_q15.sv
// Streaming Q15 dot product: multiplies accepted (a, b) pairs, accumulates
// with guard bits and presents the saturated sum on a one-entry output.
module dot_q15
   import fixed_pkg::sat16;
   import fixed_pkg::is_clip16;
   import fixed_pkg::SAT_IN_W;
#(
   parameter int ACC_W   = 24,
   parameter int MUL_LAT = fixed_pkg::MUL_LAT
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [15:0] in_a,
   input  logic signed [15:0] in_b,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic signed [15:0] out_data,
   output logic               out_sat
);

   logic [MUL_LAT:1]         r_tag_v;
   logic [MUL_LAT:1]         r_tag_l;
   logic signed [ACC_W-1:0]  r_acc;
   logic                     r_first;
   logic                     r_out_valid;
   logic signed [15:0]       r_out_data;
   logic                     r_out_sat;

   logic                     w_accept;
   logic                     w_pending;
   logic signed [15:0]       w_mul_a;
   logic signed [15:0]       w_mul_b;
   logic signed [15:0]       w_prod;
   logic signed [ACC_W-1:0]  w_prod_ext;
   logic signed [ACC_W-1:0]  w_acc_next;
   logic                     w_fire;
   logic                     w_fire_last;

   // The multiplier cannot stall, so a last beat is only admitted once the
   // previous result has fully drained; non-last beats always flow.
   assign w_pending = (|(r_tag_v & r_tag_l)) || r_out_valid;
   assign in_ready  = reset_n && (!in_last || !w_pending);
   assign w_accept  = in_valid && in_ready;

   assign w_mul_a = w_accept ? in_a : '0;
   assign w_mul_b = w_accept ? in_b : '0;

   mult u_mult (
      .clk (clk),
      .rst (~reset_n),
      .i_a (w_mul_a),
      .i_b (w_mul_b),
      .o_p (w_prod)
   );

   assign w_fire      = r_tag_v[MUL_LAT];
   assign w_fire_last = w_fire && r_tag_l[MUL_LAT];
   assign w_prod_ext  = ACC_W'(w_prod);
   assign w_acc_next  = r_first ? w_prod_ext : (r_acc + w_prod_ext);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tag_v     <= '0;
         r_tag_l     <= '0;
         r_acc       <= '0;
         r_first     <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
      end else begin
         r_tag_v[1] <= w_accept;
         r_tag_l[1] <= w_accept && in_last;
         for (int i = 2; i <= MUL_LAT; i++) begin
            r_tag_v[i] <= r_tag_v[i-1];
            r_tag_l[i] <= r_tag_l[i-1];
         end

         if (w_fire) begin
            r_acc   <= w_acc_next;
            r_first <= r_tag_l[MUL_LAT];
         end

         if (w_fire_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= sat16(SAT_IN_W'(w_acc_next));
            r_out_sat   <= is_clip16(SAT_IN_W'(w_acc_next));
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_dot_q15.sv
// Directed and randomized checks of dot_q15 against hand-computed results
// and a small Q15 reference model.
module tb_dot_q15;

   typedef struct packed {
      logic [15:0] d;
      logic        s;
   } res_t;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_last = 1'b0;
   logic signed [15:0] in_a = '0;
   logic signed [15:0] in_b = '0;
   logic               tb_ready = 1'b0;
   logic               rnd_ready = 1'b0;
   logic               rand_mode = 1'b0;
   wire                out_ready = rand_mode ? rnd_ready : tb_ready;
   wire                in_ready;
   wire                out_valid;
   wire [15:0]         out_data;
   wire                out_sat;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   res_t res_q[$];
   res_t exp_q[$];

   dot_q15 #(.ACC_W(24), .MUL_LAT(5)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // A handshake seen at the negedge completes at the following posedge.
   always @(negedge clk) begin
      res_t t;
      if (reset_n && out_valid && out_ready) begin
         t.d = out_data;
         t.s = out_sat;
         res_q.push_back(t);
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         rnd_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, cycles=%0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic int qmul(input int a, input int b);
      int p;
      p = (a * b) >>> 15;
      if (p > 32767) p = 32767;
      return p;
   endfunction

   function automatic res_t sat_res(input int s);
      res_t r;
      if (s > 32767) begin
         r.d = 16'h7FFF; r.s = 1'b1;
      end else if (s < -32768) begin
         r.d = 16'h8000; r.s = 1'b1;
      end else begin
         r.d = s[15:0];  r.s = 1'b0;
      end
      return r;
   endfunction

   // Presents one beat and returns just after the edge that accepted it.
   task automatic send(input logic signed [15:0] a, input logic signed [15:0] b,
                       input logic last, input int gap, output bit ok);
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
   endtask

   task automatic wait_res(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if (res_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_sat !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: valid=%b data=%h sat=%b, required 0 0000 0",
                  out_valid, out_data, out_sat);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, required 0", in_ready);
      end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      in_last = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_in_ready: got %b, required 1", in_ready);
      end
      in_last = 1'b0;
   endtask

   task automatic test_single();
      bit ok;
      int n;
      tb_ready = 1'b1;
      res_q.delete();
      send(16384, 16384, 1'b1, 0, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_accept: beat not accepted, required accept");
      end
      // Counting the acceptance edge, out_valid rises on the 6th edge.
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n !== 5) begin
         errors++;
         $display("FAIL single_latency: out_valid after %0d further edges, required 5", n);
      end
      checks++;
      if (out_data !== 16'h2000 || out_sat !== 1'b0) begin
         errors++;
         $display("FAIL single_data: got %h sat=%b, required 2000 sat=0", out_data, out_sat);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_clear: out_valid=%b after take, required 0", out_valid);
      end
   endtask

   task automatic test_sat4();
      bit ok;
      bit all_ok = 1'b1;
      res_q.delete();
      for (int i = 0; i < 4; i++) begin
         send(32767, 32767, (i == 3), 0, ok);
         all_ok &= ok;
      end
      wait_res(1, ok);
      checks++;
      if (!(all_ok && ok) || res_q[0] !== res_t'{16'h7FFF, 1'b1}) begin
         errors++;
         $display("FAIL sat4: got %h sat=%b (n=%0d), required 7fff sat=1",
                  res_q.size() ? res_q[0].d : 16'hxxxx, res_q.size() ? res_q[0].s : 1'bx,
                  res_q.size());
      end
   endtask

   task automatic test_mixed(input int gap);
      bit ok;
      bit all_ok = 1'b1;
      res_q.delete();
      send(-16384, 16384, 1'b0, gap, ok);     all_ok &= ok;
      send(16384, 16384, 1'b0, gap + 1, ok);  all_ok &= ok;
      send(-32768, 16384, 1'b1, gap, ok);     all_ok &= ok;
      wait_res(1, ok);
      checks++;
      if (!(all_ok && ok) || res_q[0] !== res_t'{16'hC000, 1'b0}) begin
         errors++;
         $display("FAIL mixed_gap%0d: got %h sat=%b (n=%0d), required c000 sat=0", gap,
                  res_q.size() ? res_q[0].d : 16'hxxxx, res_q.size() ? res_q[0].s : 1'bx,
                  res_q.size());
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      bit all_ok = 1'b1;
      int c0;
      int bad = 0;
      tb_ready = 1'b0;
      res_q.delete();
      send(16384, 16384, 1'b0, 0, ok);  all_ok &= ok;
      send(8192, 8192, 1'b1, 0, ok);    all_ok &= ok;
      c0 = cyc;
      send(-16384, 16384, 1'b0, 0, ok); all_ok &= ok;
      checks++;
      if (!all_ok || cyc - c0 !== 1) begin
         errors++;
         $display("FAIL bp_first_beat: accepted after %0d edges, required 1", cyc - c0);
      end
      in_a = 8192; in_b = -8192; in_last = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bp_last_blocked: in_ready high on %0d of 20 cycles, required 0", bad);
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h2800 || out_sat !== 1'b0) begin
         errors++;
         $display("FAIL bp_held: valid=%b data=%h sat=%b, required 1 2800 0",
                  out_valid, out_data, out_sat);
      end
      tb_ready = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_last = 1'b0; in_a = '0; in_b = '0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_release: last beat never accepted, required accept");
      end
      wait_res(2, ok);
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (res_q.size() != 2 || res_q[0] !== res_t'{16'h2800, 1'b0} ||
          res_q[1] !== res_t'{16'hD800, 1'b0}) begin
         errors++;
         $display("FAIL bp_results: n=%0d first=%h second=%h, required n=2 2800 d800",
                  res_q.size(), res_q.size() > 0 ? res_q[0].d : 16'hxxxx,
                  res_q.size() > 1 ? res_q[1].d : 16'hxxxx);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n;
      tb_ready = 1'b0;
      res_q.delete();
      send(16384, 16384, 1'b1, 0, ok);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      for (int i = 0; i < 3; i++) send(32767, 32767, 1'b0, 0, ok);
      reset_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      tb_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (res_q.size() != 0) begin
         errors++;
         $display("FAIL rst_discard: %0d results after reset, required 0", res_q.size());
      end
      send(8192, 8192, 1'b0, 0, ok);
      send(8192, 8192, 1'b1, 0, ok);
      wait_res(1, ok);
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (res_q.size() != 1 || res_q[0] !== res_t'{16'h1000, 1'b0}) begin
         errors++;
         $display("FAIL rst_fresh: n=%0d got %h, required n=1 1000",
                  res_q.size(), res_q.size() ? res_q[0].d : 16'hxxxx);
      end
   endtask

   task automatic test_random();
      bit ok;
      bit all_ok = 1'b1;
      int len, sum, gap, bad;
      logic signed [15:0] a, b;
      rand_mode = 1'b1;
      res_q.delete();
      exp_q.delete();
      for (int v = 0; v < 10; v++) begin
         len = (v < 3) ? $urandom_range(1, 4) : $urandom_range(1, 256);
         if (v == 9) len = 256;
         sum = 0;
         for (int i = 0; i < len; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a = 16'sh8000;
            if ($urandom_range(0, 7) == 0) b = (v == 9) ? 16'sh8000 : 16'sh7FFF;
            if (v == 9) a = 16'sh8000;
            sum += qmul(a, b);
            gap = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            send(a, b, (i == len - 1), gap, ok);
            all_ok &= ok;
         end
         exp_q.push_back(sat_res(sum));
      end
      wait_res(exp_q.size(), ok);
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (!(all_ok && ok) || res_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL rand_count: got %0d results, required %0d", res_q.size(), exp_q.size());
      end
      bad = 0;
      for (int i = 0; i < exp_q.size() && i < res_q.size(); i++) begin
         checks++;
         if (res_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL rand_vec%0d: got %h sat=%b, required %h sat=%b",
                     i, res_q[i].d, res_q[i].s, exp_q[i].d, exp_q[i].s);
         end
      end
      rand_mode = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_sat4();
      test_mixed(0);
      test_mixed(2);
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
